// File: rtl/sram_bridge_pkg.sv
// Shared types and constants for the CPU-to-async-SRAM bridge.
// Holds the access FSM state encoding, register selects and STATUS bit layout.
package sram_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE,
        W_SETUP,
        W_STROBE,
        W_HOLD,
        R_SETUP,
        R_WAIT,
        R_DONE
    } state_t;

    localparam logic [1:0] SEL_ADDR   = 2'd0;
    localparam logic [1:0] SEL_ADDRHI = 2'd1;
    localparam logic [1:0] SEL_DATA   = 2'd2;
    localparam logic [1:0] SEL_CMD    = 2'd3;

    localparam int ST_BUSY    = 0;
    localparam int ST_RVALID  = 1;
    localparam int ST_OVERRUN = 2;

    localparam int ADDR_W = 18;

endpackage

// File: rtl/sram_bridge_fsm.sv
// Access sequencer: state register, strobe-length counter and registered SRAM strobes.
// Strobes are computed from the next state so each flop matches the state it enters.
module sram_bridge_fsm
    import sram_bridge_pkg::*;
#(
    parameter int WAIT = 1
) (
    input  logic   clk,
    input  logic   resetq,
    input  logic   start_wr,
    input  logic   start_rd,
    output state_t state,
    output logic   capture,
    output logic   done,
    output logic   done_rd,
    output logic   sram_ncs,
    output logic   sram_nwe,
    output logic   sram_noe,
    output logic   sram_d_oe
);

    localparam logic [3:0] WAIT_CNT = 4'(WAIT);

    state_t     state_reg, state_next;
    logic [3:0] cnt_reg, cnt_next;
    logic       ncs_reg, nwe_reg, noe_reg, doe_reg;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (start_wr)
                    state_next = W_SETUP;
                else if (start_rd)
                    state_next = R_SETUP;
            end
            W_SETUP: begin
                state_next = W_STROBE;
                cnt_next   = WAIT_CNT;
            end
            W_STROBE: begin
                if (cnt_reg == 4'd0)
                    state_next = W_HOLD;
                else
                    cnt_next = cnt_reg - 4'd1;
            end
            W_HOLD:  state_next = IDLE;
            R_SETUP: begin
                state_next = R_WAIT;
                cnt_next   = WAIT_CNT;
            end
            R_WAIT: begin
                if (cnt_reg == 4'd0)
                    state_next = R_DONE;
                else
                    cnt_next = cnt_reg - 4'd1;
            end
            R_DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetq) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
            ncs_reg   <= 1'b1;
            nwe_reg   <= 1'b1;
            noe_reg   <= 1'b1;
            doe_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            ncs_reg   <= !(state_next inside {W_SETUP, W_STROBE, W_HOLD, R_SETUP, R_WAIT});
            nwe_reg   <= (state_next != W_STROBE);
            noe_reg   <= !(state_next inside {R_SETUP, R_WAIT});
            doe_reg   <= (state_next inside {W_SETUP, W_STROBE, W_HOLD});
        end
    end

    assign state     = state_reg;
    assign capture   = (state_reg == R_WAIT) && (cnt_reg == 4'd0);
    assign done      = (state_reg == W_HOLD) || (state_reg == R_DONE);
    assign done_rd   = (state_reg == R_DONE);
    assign sram_ncs  = ncs_reg;
    assign sram_nwe  = nwe_reg;
    assign sram_noe  = noe_reg;
    assign sram_d_oe = doe_reg;

endmodule

// File: rtl/sram_bridge.sv
// CPU IO register window onto an 8-bit asynchronous SRAM with 18-bit addressing.
// Register file and read mux live here; the access timing lives in sram_bridge_fsm.
module sram_bridge
    import sram_bridge_pkg::*;
#(
    parameter int WAIT = 1
) (
    input  logic              clk,
    input  logic              resetq,
    input  logic              io_wr,
    input  logic              io_rd,
    input  logic [1:0]        sel,
    input  logic [15:0]       wd,
    output logic [15:0]       rd,
    output logic              busy,
    output logic [ADDR_W-1:0] sram_a,
    output logic              sram_ncs,
    output logic              sram_nwe,
    output logic              sram_noe,
    output logic [7:0]        sram_d_out,
    output logic              sram_d_oe,
    input  logic [7:0]        sram_d_in
);

    logic [ADDR_W-1:0] addr_reg;
    logic              autoinc_reg;
    logic [7:0]        wdata_reg;
    logic [7:0]        rdata_reg;
    logic              rvalid_reg;
    logic              overrun_reg;

    state_t state;
    logic   idle, start_wr, start_rd, capture, done, done_rd;

    assign idle     = (state == IDLE);
    assign start_wr = io_wr && idle && (sel == SEL_DATA);
    assign start_rd = io_wr && idle && (sel == SEL_CMD) && wd[0];

    sram_bridge_fsm #(
        .WAIT(WAIT)
    ) u_fsm (
        .clk      (clk),
        .resetq   (resetq),
        .start_wr (start_wr),
        .start_rd (start_rd),
        .state    (state),
        .capture  (capture),
        .done     (done),
        .done_rd  (done_rd),
        .sram_ncs (sram_ncs),
        .sram_nwe (sram_nwe),
        .sram_noe (sram_noe),
        .sram_d_oe(sram_d_oe)
    );

    // Register writes are only taken while idle, which keeps sram_a and sram_d_out frozen mid-access.
    always_ff @(posedge clk) begin
        if (!resetq) begin
            addr_reg    <= '0;
            autoinc_reg <= 1'b0;
            wdata_reg   <= 8'd0;
            rdata_reg   <= 8'd0;
            rvalid_reg  <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            if (io_wr && !idle)
                overrun_reg <= 1'b1;
            else if (io_rd && (sel == SEL_CMD))
                overrun_reg <= 1'b0;

            if (io_wr && idle) begin
                case (sel)
                    SEL_ADDR:   addr_reg[15:0] <= wd;
                    SEL_ADDRHI: begin
                        addr_reg[17:16] <= wd[1:0];
                        autoinc_reg     <= wd[8];
                    end
                    SEL_DATA:   wdata_reg <= wd[7:0];
                    default:    ;
                endcase
            end

            if (start_wr || start_rd)
                rvalid_reg <= 1'b0;
            else if (done_rd)
                rvalid_reg <= 1'b1;

            if (capture)
                rdata_reg <= sram_d_in;

            if (done && autoinc_reg)
                addr_reg <= addr_reg + 18'd1;
        end
    end

    always_comb begin
        rd = 16'd0;
        case (sel)
            SEL_ADDR:   rd = addr_reg[15:0];
            SEL_ADDRHI: rd = {7'd0, autoinc_reg, 6'd0, addr_reg[17:16]};
            SEL_DATA:   rd = {8'd0, rdata_reg};
            default: begin
                rd[ST_BUSY]    = !idle;
                rd[ST_RVALID]  = rvalid_reg;
                rd[ST_OVERRUN] = overrun_reg;
            end
        endcase
    end

    assign busy       = !idle;
    assign sram_a     = addr_reg;
    assign sram_d_out = wdata_reg;

endmodule

// File: tb/tb_sram_bridge.sv
// Bench for sram_bridge: directed vector table, strobe-timing sequences and
// random register traffic checked against a transaction-level model with its own memory image.
module tb_sram_bridge;

    localparam int WAIT = 1;
    localparam int MEMSZ = 262144;

    logic        clk;
    logic        resetq;
    logic        io_wr;
    logic        io_rd;
    logic [1:0]  sel;
    logic [15:0] wd;
    logic [15:0] rd;
    logic        busy;
    logic [17:0] sram_a;
    logic        sram_ncs, sram_nwe, sram_noe, sram_d_oe;
    logic [7:0]  sram_d_out, sram_d_in;

    sram_bridge #(.WAIT(WAIT)) dut (
        .clk(clk), .resetq(resetq), .io_wr(io_wr), .io_rd(io_rd), .sel(sel), .wd(wd),
        .rd(rd), .busy(busy), .sram_a(sram_a), .sram_ncs(sram_ncs), .sram_nwe(sram_nwe),
        .sram_noe(sram_noe), .sram_d_out(sram_d_out), .sram_d_oe(sram_d_oe), .sram_d_in(sram_d_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural async SRAM attached to the pins
    logic [7:0] sram_mem [0:MEMSZ-1];
    always @(posedge clk) if (!sram_ncs && !sram_nwe) sram_mem[sram_a] <= sram_d_out;
    assign sram_d_in = (!sram_ncs && !sram_noe) ? sram_mem[sram_a] : 8'h00;

    // Reference model: register view plus expected memory contents
    logic [7:0]  exp_mem [0:MEMSZ-1];
    logic [17:0] m_addr;
    logic        m_auto, m_rvalid, m_over;
    logic [7:0]  m_rdata;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        bit          wr;
        logic [1:0]  s;
        logic [15:0] w;
        logic [15:0] e;
    } vec_t;
    vec_t tbl [19];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end else
            $display("ok   %s = %0h", nm, act);
    endtask

    task automatic model_reset();
        m_addr = 18'd0; m_auto = 1'b0; m_rvalid = 1'b0; m_over = 1'b0; m_rdata = 8'd0;
    endtask

    task automatic model_adv();
        if (m_auto) m_addr = (m_addr == 18'h3FFFF) ? 18'd0 : m_addr + 18'd1;
    endtask

    task automatic model_wr(input logic [1:0] s, input logic [15:0] w, output int exp_busy);
        exp_busy = 0;
        case (s)
            2'd0: m_addr[15:0] = w;
            2'd1: begin m_addr[17:16] = w[1:0]; m_auto = w[8]; end
            2'd2: begin
                exp_mem[m_addr] = w[7:0]; m_rvalid = 1'b0; model_adv(); exp_busy = WAIT + 3;
            end
            default: if (w[0]) begin
                m_rdata = exp_mem[m_addr]; m_rvalid = 1'b1; model_adv(); exp_busy = WAIT + 3;
            end
        endcase
    endtask

    task automatic model_rd(input logic [1:0] s, output logic [15:0] e);
        case (s)
            2'd0: e = m_addr[15:0];
            2'd1: e = {7'd0, m_auto, 6'd0, m_addr[17:16]};
            2'd2: e = {8'd0, m_rdata};
            default: begin e = {13'd0, m_over, m_rvalid, 1'b0}; m_over = 1'b0; end
        endcase
    endtask

    task automatic do_wr(input logic [1:0] s, input logic [15:0] w, output int nbusy);
        io_wr = 1'b1; sel = s; wd = w;
        @(negedge clk);
        io_wr = 1'b0;
        nbusy = 0;
        while (busy && nbusy < 40) begin
            nbusy++;
            @(negedge clk);
        end
    endtask

    task automatic do_rd(input logic [1:0] s, output logic [15:0] v);
        sel = s; io_rd = 1'b1;
        #1 v = rd;
        @(negedge clk);
        io_rd = 1'b0;
    endtask

    task automatic wr_model(input logic [1:0] s, input logic [15:0] w, input string nm);
        int eb, nb;
        model_wr(s, w, eb);
        do_wr(s, w, nb);
        check(nm, nb, eb);
    endtask

    task automatic rd_chk(input logic [1:0] s, input logic [15:0] e, input string nm);
        logic [15:0] v, me;
        model_rd(s, me);
        do_rd(s, v);
        check(nm, v, e);
    endtask

    task automatic measure(input logic [1:0] s, input logic [15:0] w, input bit dbl,
                           input logic [17:0] ea, input logic [7:0] ed,
                           output int c_ncs, output int c_nwe, output int c_noe, output int c_doe,
                           output int c_busy, output int c_bad, output int c_fall);
        logic prev_nwe;
        prev_nwe = 1'b1;
        c_ncs = 0; c_nwe = 0; c_noe = 0; c_doe = 0; c_busy = 0; c_bad = 0; c_fall = 0;
        io_wr = 1'b1; sel = s; wd = w;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (dbl && i == 0) wd = 16'h0011;
            else io_wr = 1'b0;
            if (!sram_ncs) begin
                c_ncs++;
                if (sram_a !== ea) c_bad++;
            end
            if (sram_d_oe) begin
                c_doe++;
                if (sram_d_out !== ed) c_bad++;
            end
            if (!sram_nwe) c_nwe++;
            if (prev_nwe && !sram_nwe) c_fall++;
            prev_nwe = sram_nwe;
            if (!sram_noe) c_noe++;
            if (busy) c_busy++;
        end
    endtask

    initial begin
        int c_ncs, c_nwe, c_noe, c_doe, c_busy, c_bad, c_fall, eb, nb;
        logic [15:0] v, e, w;
        logic [1:0]  s;

        io_wr = 1'b0; io_rd = 1'b0; sel = 2'd0; wd = 16'd0; resetq = 1'b0;
        for (int i = 0; i < MEMSZ; i++) begin sram_mem[i] = 8'h00; exp_mem[i] = 8'h00; end
        sram_mem[18'h31234] = 8'h5A; exp_mem[18'h31234] = 8'h5A;
        model_reset();

        // Reset state
        repeat (2) @(negedge clk);
        sel = 2'd3;
        #1;
        check("reset_ncs", sram_ncs, 1'b1);
        check("reset_nwe", sram_nwe, 1'b1);
        check("reset_noe", sram_noe, 1'b1);
        check("reset_doe", sram_d_oe, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_status", rd, 16'h0000);
        @(negedge clk);
        resetq = 1'b1;
        @(negedge clk);

        // Directed register-level vectors
        tbl[0]  = '{1'b1, 2'd0, 16'h1234, 16'h0000};
        tbl[1]  = '{1'b0, 2'd0, 16'h0000, 16'h1234};
        tbl[2]  = '{1'b1, 2'd1, 16'h0003, 16'h0000};
        tbl[3]  = '{1'b0, 2'd1, 16'h0000, 16'h0003};
        tbl[4]  = '{1'b1, 2'd3, 16'h0001, 16'h0000};
        tbl[5]  = '{1'b0, 2'd3, 16'h0000, 16'h0002};
        tbl[6]  = '{1'b0, 2'd2, 16'h0000, 16'h005A};
        tbl[7]  = '{1'b1, 2'd2, 16'h00A5, 16'h0000};
        tbl[8]  = '{1'b0, 2'd3, 16'h0000, 16'h0000};
        tbl[9]  = '{1'b1, 2'd3, 16'h0001, 16'h0000};
        tbl[10] = '{1'b0, 2'd2, 16'h0000, 16'h00A5};
        tbl[11] = '{1'b1, 2'd1, 16'h0103, 16'h0000};
        tbl[12] = '{1'b1, 2'd0, 16'hFFFF, 16'h0000};
        tbl[13] = '{1'b0, 2'd1, 16'h0000, 16'h0103};
        tbl[14] = '{1'b1, 2'd2, 16'h0077, 16'h0000};
        tbl[15] = '{1'b0, 2'd0, 16'h0000, 16'h0000};
        tbl[16] = '{1'b0, 2'd1, 16'h0000, 16'h0100};
        tbl[17] = '{1'b1, 2'd3, 16'h0000, 16'h0000};
        tbl[18] = '{1'b0, 2'd3, 16'h0000, 16'h0000};
        for (int i = 0; i < 19; i++) begin
            if (tbl[i].wr) wr_model(tbl[i].s, tbl[i].w, $sformatf("tbl%0d_busy", i));
            else           rd_chk(tbl[i].s, tbl[i].e, $sformatf("tbl%0d_rd", i));
        end

        // Write strobe timing
        wr_model(2'd1, 16'h0003, "wsetup_hi");
        wr_model(2'd0, 16'h1234, "wsetup_lo");
        model_wr(2'd2, 16'h00A5, eb);
        measure(2'd2, 16'h00A5, 1'b0, 18'h31234, 8'hA5, c_ncs, c_nwe, c_noe, c_doe, c_busy, c_bad, c_fall);
        check("wr_ncs_cycles", c_ncs, 4);
        check("wr_nwe_cycles", c_nwe, 2);
        check("wr_doe_cycles", c_doe, 4);
        check("wr_busy_cycles", c_busy, eb);
        check("wr_noe_cycles", c_noe, 0);
        check("wr_bus_stable", c_bad, 0);
        check("wr_sram_byte", sram_mem[18'h31234], 8'hA5);

        // Read strobe timing
        sram_mem[18'h31234] = 8'h5A; exp_mem[18'h31234] = 8'h5A;
        model_wr(2'd3, 16'h0001, eb);
        measure(2'd3, 16'h0001, 1'b0, 18'h31234, 8'h00, c_ncs, c_nwe, c_noe, c_doe, c_busy, c_bad, c_fall);
        check("rd_noe_cycles", c_noe, 3);
        check("rd_ncs_cycles", c_ncs, 3);
        check("rd_nwe_cycles", c_nwe, 0);
        check("rd_doe_cycles", c_doe, 0);
        check("rd_busy_cycles", c_busy, eb);
        rd_chk(2'd3, 16'h0002, "rd_status");
        rd_chk(2'd2, 16'h005A, "rd_data");

        // Overrun: second DATA write lands while busy
        model_wr(2'd2, 16'h0042, eb);
        m_over = 1'b1;
        measure(2'd2, 16'h0042, 1'b1, 18'h31234, 8'h42, c_ncs, c_nwe, c_noe, c_doe, c_busy, c_bad, c_fall);
        check("ovr_nwe_pulses", c_fall, 1);
        check("ovr_nwe_cycles", c_nwe, 2);
        check("ovr_bus_stable", c_bad, 0);
        rd_chk(2'd3, 16'h0004, "ovr_status_set");
        rd_chk(2'd3, 16'h0000, "ovr_status_clr");

        // Reset in the middle of a write strobe
        wr_model(2'd1, 16'h0000, "mid_hi");
        wr_model(2'd0, 16'h0005, "mid_lo");
        io_wr = 1'b1; sel = 2'd2; wd = 16'h00C3;
        @(negedge clk);
        io_wr = 1'b0;
        @(negedge clk);
        check("mid_in_strobe", sram_nwe, 1'b0);
        resetq = 1'b0;
        @(negedge clk);
        check("mid_nwe", sram_nwe, 1'b1);
        check("mid_ncs", sram_ncs, 1'b1);
        check("mid_doe", sram_d_oe, 1'b0);
        check("mid_busy", busy, 1'b0);
        resetq = 1'b1;
        exp_mem[18'h00005] = 8'hC3;
        model_reset();
        @(negedge clk);
        rd_chk(2'd0, 16'h0000, "mid_addr");

        // Randomised register traffic
        for (int n = 0; n < 80; n++) begin
            int op;
            op = int'($urandom_range(0, 5));
            case (op)
                0: wr_model(2'd0, 16'($urandom_range(0, 15)), $sformatf("rnd%0d_addr", n));
                1: wr_model(2'd1, 16'($urandom), $sformatf("rnd%0d_addrhi", n));
                2, 3: wr_model(2'd2, 16'($urandom), $sformatf("rnd%0d_data", n));
                4: wr_model(2'd3, 16'($urandom), $sformatf("rnd%0d_cmd", n));
                default: begin
                    s = 2'($urandom_range(0, 3));
                    model_rd(s, e);
                    do_rd(s, v);
                    check($sformatf("rnd%0d_rd%0d", n, s), v, e);
                end
            endcase
        end
        for (int k = 0; k < 4; k++) begin
            s = 2'(k);
            model_rd(s, e);
            do_rd(s, v);
            check($sformatf("final_rd%0d", k), v, e);
        end
        w = 16'd0;
        nb = int'(w);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + nb);
        $finish;
    end

endmodule

// File: doc/sram_bridge.md
SRAM_BRIDGE -- requirements
Module: sram_bridge

Interface
REQ-001 SHALL have parameter WAIT, default 1, meaning extra strobe cycles per SRAM access (range 0..15).
REQ-002 SHALL have port clk  input  1  single clock for all logic.
REQ-003 SHALL have port resetq  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-004 SHALL have port io_wr  input  1  CPU IO write strobe, one cycle, already qualified by the bridge's address decode.
REQ-005 SHALL have port io_rd  input  1  CPU IO read strobe, one cycle, already qualified by the bridge's address decode.
REQ-006 SHALL have port sel  input  2  register select: 0 ADDR, 1 ADDRHI, 2 DATA, 3 CMD/STATUS.
REQ-007 SHALL have port wd  input  16  CPU write data.
REQ-008 SHALL have port rd  output  16  register read data, combinational from sel and internal registers.
REQ-009 SHALL have port busy  output  1  access in progress.
REQ-010 SHALL have port sram_a  output  18  SRAM address.
REQ-011 SHALL have ports sram_ncs, sram_nwe, sram_noe  output  1 each  active-low SRAM strobes.
REQ-012 SHALL have ports sram_d_out  output  8, sram_d_oe  output  1, sram_d_in  input  8  SRAM data bus for the pad tristate.

Function
REQ-013 ADDR write SHALL load addr[15:0] from wd; read returns addr[15:0].
REQ-014 ADDRHI write SHALL load addr[17:16] from wd[1:0] and autoinc from wd[8]; read returns {7'b0, autoinc, 6'b0, addr[17:16]}.
REQ-015 DATA write SHALL latch wd[7:0] into wdata and start a write access; read returns {8'd0, rdata} with no side effect.
REQ-016 CMD write with wd[0]=1 SHALL start a read access; STATUS read returns {13'b0, overrun, rvalid, busy}, and io_rd on STATUS clears overrun.
REQ-017 Any io_wr to ADDR, ADDRHI, DATA or CMD while busy SHALL be ignored and set overrun; io_rd has no effect on state except REQ-016.
REQ-018 FSM states SHALL be IDLE, W_SETUP, W_STROBE, W_HOLD, R_SETUP, R_WAIT, R_DONE.
REQ-019 Write SHALL run W_SETUP (1 cycle) -> W_STROBE (WAIT+1 cycles) -> W_HOLD (1 cycle) -> IDLE.
REQ-020 Read SHALL run R_SETUP (1 cycle) -> R_WAIT (WAIT+1 cycles) -> R_DONE (1 cycle) -> IDLE.
REQ-021 Access SHALL leave IDLE on the edge that samples the starting io_wr; busy=1 in every non-IDLE state, so each access is busy for WAIT+3 cycles.
REQ-022 sram_ncs=0 in all W_* and R_SETUP/R_WAIT; sram_nwe=0 only in W_STROBE; sram_noe=0 only in R_SETUP/R_WAIT; sram_d_oe=1 only in W_*.
REQ-023 All SRAM strobes and sram_d_oe SHALL be driven directly from flip-flops (glitch-free); sram_a and sram_d_out SHALL be held stable through every non-IDLE state.
REQ-024 rdata SHALL capture sram_d_in on the edge leaving R_WAIT.
REQ-025 rvalid SHALL clear when any access starts and set on the edge R_DONE -> IDLE.
REQ-026 If autoinc=1, addr SHALL increment by 1 on the edge entering IDLE from W_HOLD or R_DONE, wrapping 0x3FFFF -> 0x00000.
REQ-027 After entering IDLE, a new access SHALL be accepted in the next cycle (back-to-back with zero idle gap).

Reset
REQ-028 resetq=0 at any rising clk SHALL force IDLE, sram_ncs/nwe/noe=1, sram_d_oe=0, addr=0, autoinc=0, wdata=0, rdata=0, rvalid=0, overrun=0, busy=0, including mid-access (strobes released on that same edge).

Structure
REQ-029 Package sram_bridge_pkg SHALL hold the FSM state enum, the register-select constants and the STATUS bit positions.
REQ-030 Sub-module sram_bridge_fsm SHALL contain the state register, the wait counter and the strobe flops; the register file and read mux stay in sram_bridge.

Verification
REQ-031 Reset check: hold resetq=0 for 2 cycles -> ncs=nwe=noe=1, d_oe=0, busy=0, STATUS=0x0000.
REQ-032 Write (WAIT=1): ADDR=0x1234, ADDRHI=0x0003, DATA=0x00A5 -> sram_a=0x31234, d_out=0xA5, ncs low 4 cycles, nwe low exactly 2 cycles, d_oe high 4 cycles, busy 4 cycles.
REQ-033 Read: SRAM model returns 0x5A at 0x31234, CMD=0x0001 -> noe low 3 cycles, then STATUS=0x0002 and DATA reads 0x005A.
REQ-034 Autoinc wrap: ADDRHI=0x0103, ADDR=0xFFFF, DATA write -> afterwards ADDR reads 0x0000 and ADDRHI reads 0x0100.
REQ-035 Overrun: two DATA writes 1 cycle apart -> only one nwe pulse, STATUS bit2=1; STATUS read clears it to 0.
REQ-036 Reset mid-write: resetq=0 during W_STROBE -> after that edge nwe=1, ncs=1, d_oe=0, busy=0.
